// File: rtl/indexed_queue_pkg.sv
// Shared types and width helpers for indexed_queue: the per-cycle accepted-operation
// decode and the derived index/count widths.
package indexed_queue_pkg;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_ADD,
    OP_REM,
    OP_BOTH
  } op_e;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return (depth > 0) ? $clog2(depth + 1) : 1;
  endfunction

endpackage

// File: rtl/indexed_queue_slot.sv
// One storage entry of indexed_queue: holds, shifts down from its upper neighbour
// during compaction, or loads the appended data.
module indexed_queue_slot
  import indexed_queue_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int CNT_W = 3,
  parameter int SLOT  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  op_e              op,
  input  logic [CNT_W-1:0] count,
  input  logic [CNT_W-1:0] rem_idx,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] upper,
  output logic [WIDTH-1:0] q
);

  localparam logic [CNT_W-1:0] SLOT_C = CNT_W'(SLOT);
  localparam logic [CNT_W-1:0] SLOT_N = CNT_W'(SLOT + 1);

  logic shift;
  logic load_in;

  // Compaction moves slots index..count-2 down; the append lands after compaction.
  always_comb begin
    shift   = 1'b0;
    load_in = 1'b0;
    case (op)
      OP_ADD:  load_in = (SLOT_C == count);
      OP_REM:  shift   = (SLOT_C >= rem_idx) && (SLOT_N < count);
      OP_BOTH: begin
        shift   = (SLOT_C >= rem_idx) && (SLOT_N < count);
        load_in = (SLOT_N == count);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load_in) begin
      q <= in;
    end else if (shift) begin
      q <= upper;
    end
  end

endmodule

// File: rtl/indexed_queue.sv
// Insertion-ordered buffer with random-index extraction and automatic compaction.
// Optional peek port enabled by defining INDEXED_QUEUE_PEEK_EN.
module indexed_queue
  import indexed_queue_pkg::*;
#(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 5,
  localparam int IDX_W = idx_width(DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
`ifdef INDEXED_QUEUE_PEEK_EN
  input  logic [IDX_W-1:0] peek_index,
  output logic [WIDTH-1:0] peek_data,
`endif
  input  logic [WIDTH-1:0] in,
  input  logic             add,
  input  logic [IDX_W-1:0] index,
  input  logic             remove,
  output logic [WIDTH-1:0] out,
  output logic             add_finish,
  output logic             remove_finish,
  output logic             remove_error,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] q     [DEPTH];
  logic [WIDTH-1:0] upper [DEPTH];
  logic [CNT_W-1:0] rem_idx;
  logic [CNT_W-1:0] count_nxt;
  logic [WIDTH-1:0] sel_data;
  logic             rem_ok;
  logic             add_ok;
  op_e              op;

  assign rem_idx = CNT_W'(index);
  assign rem_ok  = remove && (rem_idx < count);
  assign add_ok  = add && ((count < DEPTH_C) || rem_ok);

  always_comb begin
    op        = OP_IDLE;
    count_nxt = count;
    if (add_ok && rem_ok) begin
      op = OP_BOTH;
    end else if (add_ok) begin
      op        = OP_ADD;
      count_nxt = count + 1'b1;
    end else if (rem_ok) begin
      op        = OP_REM;
      count_nxt = count - 1'b1;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rem_idx == CNT_W'(i)) sel_data = q[i];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    if (g == DEPTH - 1) begin : g_top
      assign upper[g] = '0;
    end else begin : g_mid
      assign upper[g] = q[g+1];
    end

    indexed_queue_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W),
      .SLOT  (g)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .op      (op),
      .count   (count),
      .rem_idx (rem_idx),
      .in      (in),
      .upper   (upper[g]),
      .q       (q[g])
    );
  end

  // Output register stage: pulses, extracted data and occupancy flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      out           <= '0;
      count         <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      add_finish    <= 1'b0;
      remove_finish <= 1'b0;
      remove_error  <= 1'b0;
    end else begin
      add_finish    <= add_ok;
      remove_finish <= rem_ok;
      remove_error  <= remove && !rem_ok;
      if (rem_ok) out <= sel_data;
      count         <= count_nxt;
      full          <= (count_nxt == DEPTH_C);
      empty         <= (count_nxt == '0);
    end
  end

`ifdef INDEXED_QUEUE_PEEK_EN
  always_comb begin
    peek_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(peek_index) == CNT_W'(i)) && (CNT_W'(i) < count)) peek_data = q[i];
    end
  end
`else
  // Without the peek path, storage is observable only through out.
`endif

endmodule

// File: tb/tb_indexed_queue.sv
// Scoreboard bench for indexed_queue (DEPTH=5, WIDTH=10); peek checks are included
// when INDEXED_QUEUE_PEEK_EN is defined.
module tb_indexed_queue;

  localparam int WIDTH = 10;
  localparam int DEPTH = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] in_d = '0;
  logic             add = 1'b0;
  logic [2:0]       index = '0;
  logic             remove = 1'b0;
  logic [WIDTH-1:0] out;
  logic             add_finish;
  logic             remove_finish;
  logic             remove_error;
  logic             full;
  logic             empty;
  logic [2:0]       count;
`ifdef INDEXED_QUEUE_PEEK_EN
  logic [2:0]       peek_index = '0;
  logic [WIDTH-1:0] peek_data;
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    int         id;
    logic       af;
    logic       rf;
    logic       re;
    logic [9:0] dout;
    logic [2:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  indexed_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef INDEXED_QUEUE_PEEK_EN
    .peek_index    (peek_index),
    .peek_data     (peek_data),
`endif
    .in            (in_d),
    .add           (add),
    .index         (index),
    .remove        (remove),
    .out           (out),
    .add_finish    (add_finish),
    .remove_finish (remove_finish),
    .remove_error  (remove_error),
    .full          (full),
    .empty         (empty),
    .count         (count)
  );

  int vec_id = 0;

  task automatic step(input bit a, input logic [9:0] d, input bit r, input logic [2:0] idx,
                      input bit rs, input bit eaf, input bit erf, input bit ere,
                      input logic [9:0] eo, input logic [2:0] ec);
    exp_t e;
    @(negedge clk);
    add    = a;
    in_d   = d;
    remove = r;
    index  = idx;
    reset  = rs;
    e.id   = vec_id;
    e.af   = eaf;
    e.rf   = erf;
    e.re   = ere;
    e.dout = eo;
    e.cnt  = ec;
    vec_id++;
    exp_q.push_back(e);
  endtask

  // Monitor: every edge that consumed a stimulus vector is checked one step later.
  initial begin
    exp_t e;
    logic ef;
    logic ee;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ef = (e.cnt == 3'd5);
        ee = (e.cnt == 3'd0);
        vectors++;
        if (add_finish !== e.af || remove_finish !== e.rf || remove_error !== e.re ||
            out !== e.dout || count !== e.cnt || full !== ef || empty !== ee) begin
          miscompares++;
          $display("FAIL vec%0d: got af=%b rf=%b re=%b out=%h cnt=%0d full=%b empty=%b; want af=%b rf=%b re=%b out=%h cnt=%0d full=%b empty=%b",
                   e.id, add_finish, remove_finish, remove_error, out, count, full, empty,
                   e.af, e.rf, e.re, e.dout, e.cnt, ef, ee);
        end
      end
    end
  end

`ifdef INDEXED_QUEUE_PEEK_EN
  task automatic peek_check(input logic [2:0] pi, input logic [9:0] want);
    @(posedge clk);
    #2;
    peek_index = pi;
    #1;
    vectors++;
    if (peek_data !== want) begin
      miscompares++;
      $display("FAIL peek[%0d]: got %h want %h", pi, peek_data, want);
    end
  endtask
`endif

  initial begin
    //    add d      rem idx rst  af rf re out     cnt
    step(0, 10'h000, 0, 0, 1,   0, 0, 0, 10'h000, 0);
    step(0, 10'h000, 0, 0, 1,   0, 0, 0, 10'h000, 0);
    // ordering
    step(1, 10'h011, 0, 0, 0,   1, 0, 0, 10'h000, 1);
    step(1, 10'h022, 0, 0, 0,   1, 0, 0, 10'h000, 2);
    step(1, 10'h033, 0, 0, 0,   1, 0, 0, 10'h000, 3);
    step(0, 10'h000, 1, 1, 0,   0, 1, 0, 10'h022, 2);
    step(0, 10'h000, 1, 0, 0,   0, 1, 0, 10'h011, 1);
    step(0, 10'h000, 1, 0, 0,   0, 1, 0, 10'h033, 0);
    // fill, reject when full, add+remove while full
    step(1, 10'h001, 0, 0, 0,   1, 0, 0, 10'h033, 1);
    step(1, 10'h002, 0, 0, 0,   1, 0, 0, 10'h033, 2);
    step(1, 10'h003, 0, 0, 0,   1, 0, 0, 10'h033, 3);
    step(1, 10'h004, 0, 0, 0,   1, 0, 0, 10'h033, 4);
    step(1, 10'h005, 0, 0, 0,   1, 0, 0, 10'h033, 5);
    step(1, 10'h006, 0, 0, 0,   0, 0, 0, 10'h033, 5);
    step(1, 10'h007, 1, 4, 0,   1, 1, 0, 10'h005, 5);
    step(0, 10'h000, 1, 4, 0,   0, 1, 0, 10'h007, 4);
    step(0, 10'h000, 1, 0, 0,   0, 1, 0, 10'h001, 3);
    step(0, 10'h000, 1, 1, 0,   0, 1, 0, 10'h003, 2);
    // index errors: beyond count, and beyond DEPTH
    step(0, 10'h000, 1, 3, 0,   0, 0, 1, 10'h003, 2);
    step(0, 10'h000, 1, 7, 0,   0, 0, 1, 10'h003, 2);
    step(0, 10'h000, 1, 1, 0,   0, 1, 0, 10'h004, 1);
    step(0, 10'h000, 1, 0, 0,   0, 1, 0, 10'h002, 0);
    // remove on empty with concurrent add
    step(1, 10'h0AA, 1, 0, 0,   1, 0, 1, 10'h002, 1);
    step(1, 10'h0BB, 0, 0, 0,   1, 0, 0, 10'h002, 2);
    step(1, 10'h0CC, 0, 0, 0,   1, 0, 0, 10'h002, 3);
    // reset overrides add+remove
    step(1, 10'h0DD, 1, 0, 1,   0, 0, 0, 10'h000, 0);
    step(0, 10'h000, 0, 0, 0,   0, 0, 0, 10'h000, 0);
    // partial occupancy, simultaneous add+remove keeps order
    step(1, 10'h011, 0, 0, 0,   1, 0, 0, 10'h000, 1);
    step(1, 10'h022, 0, 0, 0,   1, 0, 0, 10'h000, 2);
    step(1, 10'h033, 0, 0, 0,   1, 0, 0, 10'h000, 3);
    step(0, 10'h000, 0, 0, 0,   0, 0, 0, 10'h000, 3);
`ifdef INDEXED_QUEUE_PEEK_EN
    peek_check(3'd2, 10'h033);
    peek_check(3'd4, 10'h000);
    peek_check(3'd0, 10'h011);
`endif
    step(1, 10'h044, 1, 0, 0,   1, 1, 0, 10'h011, 3);
    step(0, 10'h000, 1, 2, 0,   0, 1, 0, 10'h044, 2);
    // remove held for three cycles: three requests
    step(0, 10'h000, 1, 0, 0,   0, 1, 0, 10'h022, 1);
    step(0, 10'h000, 1, 0, 0,   0, 1, 0, 10'h033, 0);
    step(0, 10'h000, 1, 0, 0,   0, 0, 1, 10'h033, 0);
    step(0, 10'h000, 0, 0, 0,   0, 0, 0, 10'h033, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors never checked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
